// File: rtl/img_pkg.sv
// Shared frame geometry, pixel-address width and reader state encoding
// for the segmented-image stream producer.
package img_pkg;

  localparam int IMG_W_DEF    = 160;
  localparam int IMG_H_DEF    = 120;
  localparam int LINE_PAD_DEF = 2;
  localparam int PIX_ADDR_W   = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PIX   = 3'd2,
    PAD   = 3'd3,
    DONE  = 3'd4
  } rd_state_t;

endpackage

// File: rtl/object_frame_ram.sv
// Two-bank 1-bit frame store: one write port, one registered read port whose
// enable lets the reader hold its prefetched pixel during a stall.
module object_frame_ram
  import img_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF * IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [PIX_ADDR_W-1:0] wr_addr,
  input  logic                  wr_data,
  input  logic                  rd_en,
  input  logic                  rd_bank,
  input  logic [PIX_ADDR_W-1:0] rd_addr,
  output logic                  rd_data
);

  logic mem0 [DEPTH];
  logic mem1 [DEPTH];

  // Write port into the selected bank
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) begin
        mem1[wr_addr] <= wr_data;
      end else begin
        mem0[wr_addr] <= wr_data;
      end
    end
  end

  // Registered read; data holds while rd_en is low
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

endmodule

// File: rtl/object_image_streamer.sv
// Captures segmented object pixels into a ping-pong frame buffer and replays each
// completed frame as a raster stream with row/col tags and per-row zero padding.
module object_image_streamer
  import img_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int LINE_PAD = LINE_PAD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_pixel,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_pixel,
  output logic       out_sof,
  output logic       out_eol,
  output logic [7:0] out_row,
  output logic [7:0] out_col,
  output logic       busy
);

  localparam logic [PIX_ADDR_W-1:0] LAST_ADDR    = PIX_ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [7:0]            LAST_PIX_COL = 8'(IMG_W - 1);
  localparam logic [7:0]            LAST_COL     = 8'(IMG_W + LINE_PAD - 1);
  localparam logic [7:0]            LAST_ROW     = 8'(IMG_H - 1);

  rd_state_t             state, state_nxt;
  logic [1:0]            full;
  logic                  wr_bank, rd_bank, rd_bank_nxt;
  logic [PIX_ADDR_W-1:0] wr_addr, rd_addr, rd_addr_nxt;
  logic [7:0]            row, row_nxt, col, col_nxt;
  logic                  rd_en, rel_bank, rd_data;
  logic                  wr_fire, wr_last, other_free;

  assign in_ready  = !full[wr_bank];
  assign wr_fire   = in_valid && in_ready;
  assign wr_last   = wr_fire && (wr_addr == LAST_ADDR);
  assign rel_bank  = (state == DONE);
  // A bank released this very cycle counts as free so the writer never stalls on it
  assign other_free = !full[!wr_bank] || (rel_bank && (rd_bank != wr_bank));

  assign out_valid = (state == PIX) || (state == PAD);
  assign out_pixel = rd_data && (state == PIX);
  assign out_sof   = out_valid && (row == 8'd0) && (col == 8'd0);
  assign out_eol   = out_valid && (col == LAST_COL);
  assign out_row   = row;
  assign out_col   = col;
  assign busy      = (state != IDLE);

  // Writer address, write-bank selection and bank-full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (wr_fire) begin
        wr_addr <= wr_last ? '0 : wr_addr + 15'd1;
      end
      if ((wr_last || full[wr_bank]) && other_free) begin
        wr_bank <= !wr_bank;
      end
      full[0] <= (full[0] && !(rel_bank && !rd_bank)) || (wr_last && !wr_bank);
      full[1] <= (full[1] && !(rel_bank && rd_bank)) || (wr_last && wr_bank);
    end
  end

  // Reader state and position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
      row     <= 8'd0;
      col     <= 8'd0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      rd_addr <= rd_addr_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
    end
  end

  // Reader next state; rd_addr always points at the next pixel to prefetch
  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    rd_addr_nxt = rd_addr;
    row_nxt     = row;
    col_nxt     = col;
    rd_en       = 1'b0;
    case (state)
      IDLE: begin
        rd_addr_nxt = '0;
        if (full[!wr_bank]) begin
          rd_bank_nxt = !wr_bank;
          state_nxt   = FETCH;
        end else if (full[wr_bank]) begin
          rd_bank_nxt = wr_bank;
          state_nxt   = FETCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FETCH: begin
        rd_en       = 1'b1;
        rd_addr_nxt = rd_addr + 15'd1;
        state_nxt   = PIX;
      end
      PIX: begin
        if (out_ready && (col != LAST_COL)) begin
          col_nxt = col + 8'd1;
          if (col == LAST_PIX_COL) begin
            state_nxt = PAD;
          end else begin
            rd_en       = 1'b1;
            rd_addr_nxt = rd_addr + 15'd1;
          end
        end else begin
          col_nxt = col;
        end
      end
      PAD: begin
        if (out_ready && (col != LAST_COL)) begin
          col_nxt = col + 8'd1;
        end else begin
          col_nxt = col;
        end
      end
      DONE: begin
        rd_addr_nxt = '0;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // End-of-row beat, shared by PIX (no padding) and PAD
    if (out_valid && out_ready && (col == LAST_COL)) begin
      col_nxt = 8'd0;
      if (row == LAST_ROW) begin
        row_nxt   = 8'd0;
        state_nxt = DONE;
      end else begin
        row_nxt     = row + 8'd1;
        state_nxt   = PIX;
        rd_en       = 1'b1;
        rd_addr_nxt = rd_addr + 15'd1;
      end
    end else begin
      rd_bank_nxt = rd_bank_nxt;
    end
  end

  object_frame_ram #(
    .DEPTH(IMG_W * IMG_H)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_fire),
    .wr_bank(wr_bank),
    .wr_addr(wr_addr),
    .wr_data(in_pixel),
    .rd_en  (rd_en),
    .rd_bank(rd_bank),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_object_image_streamer.sv
// Directed bench: a default-size streamer plus two small builds (with and without
// line padding) driven with known frames and compared beat by beat.
module tb_object_image_streamer;

  logic       clk;
  logic       rst       [3];
  logic       in_valid  [3];
  logic       in_pixel  [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic       out_pixel [3];
  logic       out_sof   [3];
  logic       out_eol   [3];
  logic [7:0] out_row   [3];
  logic [7:0] out_col   [3];
  logic       busy      [3];

  int checks   = 0;
  int failures = 0;
  int lat;
  int t;

  object_image_streamer u_def (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_pixel(in_pixel[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_pixel(out_pixel[0]), .out_sof(out_sof[0]), .out_eol(out_eol[0]),
    .out_row(out_row[0]), .out_col(out_col[0]), .busy(busy[0])
  );

  object_image_streamer #(.IMG_W(6), .IMG_H(3), .LINE_PAD(2)) u_pad (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_pixel(in_pixel[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_pixel(out_pixel[1]), .out_sof(out_sof[1]), .out_eol(out_eol[1]),
    .out_row(out_row[1]), .out_col(out_col[1]), .busy(busy[1])
  );

  object_image_streamer #(.IMG_W(6), .IMG_H(3), .LINE_PAD(0)) u_nopad (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_pixel(in_pixel[2]),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_pixel(out_pixel[2]), .out_sof(out_sof[2]), .out_eol(out_eol[2]),
    .out_row(out_row[2]), .out_col(out_col[2]), .busy(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int w_of(input int d);
    return (d == 0) ? 160 : 6;
  endfunction

  function automatic int h_of(input int d);
    return (d == 0) ? 120 : 3;
  endfunction

  function automatic int p_of(input int d);
    return (d == 2) ? 0 : 2;
  endfunction

  // Frame content: default build carries a single set pixel at address 0
  function automatic logic pix_fn(input int d, input int f, input int a);
    if (d == 0) return (a == 0);
    return (((a * 7) + (f * 11) + d) % 5) < 2;
  endfunction

  // {valid, pixel, sof, eol, row, col} expected for beat k of frame f
  function automatic logic [19:0] exp_beat(input int d, input int f, input int k);
    int  wp;
    int  r;
    int  c;
    logic px;
    wp = w_of(d) + p_of(d);
    r  = k / wp;
    c  = k % wp;
    px = (c < w_of(d)) ? pix_fn(d, f, r * w_of(d) + c) : 1'b0;
    return {1'b1, px, (k == 0), (c == wp - 1), 8'(r), 8'(c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put_px(input int d, input logic p);
    int w = 0;
    in_valid[d] = 1'b1;
    in_pixel[d] = p;
    while (!in_ready[d] && w < 2000) begin
      tick();
      w++;
    end
    if (w >= 2000) check("in_ready_wait", 32'(w), 32'd0);
    tick();
    in_valid[d] = 1'b0;
  endtask

  task automatic put_frame(input int d, input int f);
    for (int a = 0; a < w_of(d) * h_of(d); a++) put_px(d, pix_fn(d, f, a));
  endtask

  // Consumes one frame; optional random stalls, checks every beat and stall holding
  task automatic mon_frame(input int d, input int f, input bit stall, input int limit);
    int          k = 0;
    int          cyc = 0;
    int          total;
    bit          have_snap = 1'b0;
    logic [19:0] snap = '0;
    logic [19:0] cur;
    total = h_of(d) * (w_of(d) + p_of(d));
    while (k < total && cyc < limit) begin
      out_ready[d] = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
      cur = {out_valid[d], out_pixel[d], out_sof[d], out_eol[d], out_row[d], out_col[d]};
      if (have_snap) check("stall_hold", 32'(cur), 32'(snap));
      have_snap = 1'b0;
      if (out_valid[d] && out_ready[d]) begin
        check("beat", 32'(cur), 32'(exp_beat(d, f, k)));
        k++;
      end else if (out_valid[d]) begin
        snap      = cur;
        have_snap = 1'b1;
      end
      tick();
      cyc++;
    end
    check("frame_beats", 32'(k), 32'(total));
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d]       = 1'b1;
      in_valid[d]  = 1'b0;
      in_pixel[d]  = 1'b0;
      out_ready[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", 32'(in_ready[d]), 32'd1);
      check("rst_outs", 32'({out_valid[d], out_pixel[d], out_sof[d], out_eol[d],
                             busy[d], out_row[d], out_col[d]}), 32'd0);
      rst[d] = 1'b0;
    end
    tick();

    // Default geometry: single-pixel frame, back-to-back drain, first-beat latency
    out_ready[0] = 1'b1;
    fork
      begin
        put_frame(0, 0);
        lat = 0;
        while (!out_valid[0] && lat < 10) begin
          tick();
          lat++;
        end
        check("first_beat_latency", 32'(lat), 32'd2);
      end
      mon_frame(0, 0, 1'b0, 45000);
    join
    check("busy_in_done", 32'({busy[0], out_valid[0]}), 32'b10);
    tick();
    check("busy_after_done", 32'(busy[0]), 32'd0);

    // Two frames captured with the consumer blocked, third waits for a free bank
    put_frame(1, 0);
    put_frame(1, 1);
    check("in_ready_both_full", 32'(in_ready[1]), 32'd0);
    repeat (4) tick();
    check("in_ready_held", 32'(in_ready[1]), 32'd0);
    check("beat0_held", 32'({out_valid[1], out_pixel[1], out_sof[1], out_eol[1],
                             out_row[1], out_col[1]}), 32'(exp_beat(1, 0, 0)));
    fork
      put_frame(1, 2);
      begin
        mon_frame(1, 0, 1'b0, 2000);
        mon_frame(1, 1, 1'b1, 2000);
        mon_frame(1, 2, 1'b1, 2000);
      end
    join

    // Reset in the middle of a row, then a fresh frame must start at sof
    out_ready[1] = 1'b1;
    put_frame(1, 3);
    t = 0;
    while (!(out_valid[1] && out_row[1] == 8'd1 && out_col[1] == 8'd2) && t < 200) begin
      tick();
      t++;
    end
    check("reach_mid_row", 32'(t < 200), 32'd1);
    rst[1] = 1'b1;
    tick();
    check("rst_mid_in_ready", 32'(in_ready[1]), 32'd1);
    check("rst_mid_outs", 32'({out_valid[1], busy[1], out_row[1], out_col[1]}), 32'd0);
    rst[1] = 1'b0;
    fork
      put_frame(1, 4);
      mon_frame(1, 4, 1'b0, 2000);
    join

    // No line padding: eol on the last pixel column
    fork
      begin
        put_frame(2, 0);
        put_frame(2, 1);
      end
      begin
        mon_frame(2, 0, 1'b1, 2000);
        mon_frame(2, 1, 1'b0, 2000);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
